// File: rtl/i2c_pkg.sv
// Shared definitions for the i2c request arbiter: default widths, arbiter
// state encoding and a round-robin pointer helper.
package i2c_pkg;

   localparam int unsigned I2C_ADDR_W = 7;
   localparam int unsigned I2C_DATA_W = 8;

   typedef enum logic [1:0] {
      ARB_IDLE     = 2'd0,
      ARB_ISSUE    = 2'd1,
      ARB_BUSY     = 2'd2,
      ARB_COMPLETE = 2'd3
   } arb_state_e;

   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/i2c_req_arbiter_rr_picker.sv
// Combinational round-robin selector: first set request at or after the
// pointer, wrapping modulo N; one-hot grant plus binary index.
module rr_picker #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = IDX_W'((32'(ptr_i) + i) % N);
         if (!valid_o && req_i[cand]) begin
            valid_o     = 1'b1;
            idx_o       = cand;
            gnt_o[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one i2c_master between NUM_REQ requesters.
// Optional transaction timeout abort: define I2C_ARB_TIMEOUT_EN.
module i2c_req_arbiter
   import i2c_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned ADDR_W         = I2C_ADDR_W,
   parameter int unsigned DATA_W         = I2C_DATA_W,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_rw,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        done,
   output logic [DATA_W-1:0]         rdata,
   output logic                      err,
   output logic [ADDR_W-1:0]         m_addr,
   output logic [DATA_W-1:0]         m_data_in,
   output logic                      m_rw,
   output logic                      m_enable,
   input  logic                      m_ready,
   input  logic [DATA_W-1:0]         m_read_data
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("i2c_req_arbiter: NUM_REQ must be in 2..8");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("i2c_req_arbiter: TIMEOUT_CYCLES must be at least 2");
   end

   arb_state_e         state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0]   gidx_q, gidx_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic [ADDR_W-1:0]  m_addr_q, m_addr_d;
   logic [DATA_W-1:0]  m_data_q, m_data_d;
   logic               m_rw_q, m_rw_d;
   logic               m_enable_q, m_enable_d;

   logic [NUM_REQ-1:0] pick_gnt;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_valid;

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tout_q, tout_d;
`endif

   rr_picker #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .gnt_o   (pick_gnt),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      gidx_d     = gidx_q;
      ptr_d      = ptr_q;
      rdata_d    = rdata_q;
      m_addr_d   = m_addr_q;
      m_data_d   = m_data_q;
      m_rw_d     = m_rw_q;
      m_enable_d = m_enable_q;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_d      = cnt_q;
      tout_d     = tout_q;
`endif
      unique case (state_q)
         ARB_IDLE: begin
            if (m_ready && pick_valid) begin
               gnt_d      = pick_gnt;
               gidx_d     = pick_idx;
               m_addr_d   = req_addr[32'(pick_idx)*ADDR_W +: ADDR_W];
               m_data_d   = req_wdata[32'(pick_idx)*DATA_W +: DATA_W];
               m_rw_d     = req_rw[pick_idx];
               m_enable_d = 1'b1;
               state_d    = ARB_ISSUE;
`ifdef I2C_ARB_TIMEOUT_EN
               cnt_d      = '0;
               tout_d     = 1'b0;
`endif
            end
         end
         ARB_ISSUE: begin
            if (!m_ready) begin
               m_enable_d = 1'b0;
               state_d    = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            if (m_ready) begin
               rdata_d = m_read_data;
               state_d = ARB_COMPLETE;
            end
         end
         ARB_COMPLETE: begin
            gnt_d   = '0;
            ptr_d   = IDX_W'(rr_next(32'(gidx_q), NUM_REQ));
            state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
`ifdef I2C_ARB_TIMEOUT_EN
      // A normal completion in the same cycle as expiry wins over the abort.
      if (state_q == ARB_ISSUE || (state_q == ARB_BUSY && !m_ready)) begin
         if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            m_enable_d = 1'b0;
            tout_d     = 1'b1;
            state_d    = ARB_COMPLETE;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ARB_IDLE;
         gnt_q      <= '0;
         gidx_q     <= '0;
         ptr_q      <= '0;
         rdata_q    <= '0;
         m_addr_q   <= '0;
         m_data_q   <= '0;
         m_rw_q     <= 1'b0;
         m_enable_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         gidx_q     <= gidx_d;
         ptr_q      <= ptr_d;
         rdata_q    <= rdata_d;
         m_addr_q   <= m_addr_d;
         m_data_q   <= m_data_d;
         m_rw_q     <= m_rw_d;
         m_enable_q <= m_enable_d;
      end
   end

`ifdef I2C_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tout_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tout_q <= tout_d;
      end
   end

   assign err = (state_q == ARB_COMPLETE) & tout_q;
`else
   assign err = 1'b0;
`endif

   assign done      = (state_q == ARB_COMPLETE) ? gnt_q : '0;
   assign gnt       = gnt_q;
   assign rdata     = rdata_q;
   assign m_addr    = m_addr_q;
   assign m_data_in = m_data_q;
   assign m_rw      = m_rw_q;
   assign m_enable  = m_enable_q;

endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
- Shares one i2c_master between NUM_REQ independent requesters.
- Round-robin arbitration; sequences the master's enable/ready handshake; returns read data, a done pulse and an error flag to the granted requester.
- Sits between client logic and the i2c_master's addr/data_in/rw/enable/ready/read_data ports.
- Runs entirely in the system clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 7, I2C slave address width
- DATA_W, 8, data byte width
- TIMEOUT_CYCLES, 4096, maximum clk cycles per transaction before abort (timeout build only)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester request, level; held until its done
- req_rw  in  NUM_REQ  per-requester direction, 1=read 0=write
- req_addr  in  NUM_REQ*ADDR_W  packed slave addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write bytes
- gnt  out  NUM_REQ  one-hot grant, high from issue through done
- done  out  NUM_REQ  one-cycle completion pulse to granted requester
- rdata  out  DATA_W  read byte, valid in done cycle
- err  out  1  high with done when transaction timed out
- m_addr  out  ADDR_W  to master addr
- m_data_in  out  DATA_W  to master data_in
- m_rw  out  1  to master rw
- m_enable  out  1  to master enable
- m_ready  in  1  from master ready (1 = idle)
- m_read_data  in  DATA_W  from master read_data

Behaviour:
- Reset (asynchronous, any state): state=IDLE; gnt=0; done=0; err=0; rdata=0; m_enable=0; m_addr=0; m_data_in=0; m_rw=0; RR pointer=0; timeout counter=0.
- States:
  - IDLE: when m_ready=1 and any req is high, pick the first set req at or after the pointer, wrapping modulo NUM_REQ. Register the winner's addr/wdata/rw into the m_* outputs, set gnt one-hot and m_enable=1, go to ISSUE. If m_ready=0, wait.
  - ISSUE: hold m_enable=1 and operands. When m_ready=0 (master accepted), drop m_enable and go to BUSY.
  - BUSY: when m_ready returns to 1, capture m_read_data into rdata and go to COMPLETE.
  - COMPLETE: pulse done[g]=1 for one cycle; clear gnt; pointer = g+1 mod NUM_REQ; go to IDLE.
- Latency: req sampled high at edge t gives gnt and m_enable high after edge t; minimum 3 cycles from issue to done.
- m_* operands stay stable from issue through COMPLETE; requester inputs are ignored after latch.
- Deasserting req mid-transaction does not abort; done is still pulsed.
- req still high in the cycle after done counts as a new request; rotation gives other pending requesters priority first.
- Simultaneous requests: strict rotation, no starvation; worst-case wait is NUM_REQ-1 transactions.
- rdata is updated for writes too (contents don't-care) and holds until the next completion.
- err=0 except as described under Optional Feature.

Optional Feature:
- Macro: I2C_ARB_TIMEOUT_EN.
- Defined: a counter clears on issue and increments in ISSUE/BUSY. On reaching TIMEOUT_CYCLES-1, m_enable drops, state goes to COMPLETE, and done pulses with err=1; rdata keeps its previous value. err is a one-cycle pulse coincident with done.
- Undefined: no counter; err is tied 0; ISSUE/BUSY wait indefinitely.

Decomposition:
- Shared package i2c_pkg: state encoding constants (ARB_IDLE, ARB_ISSUE, ARB_BUSY, ARB_COMPLETE), default ADDR_W/DATA_W.
- One sub-module: rr_picker, combinational round-robin select (req vector + pointer in, one-hot grant + index out), reusable elsewhere.

Test Plan:
- Single write: req[0]=1, addr 7'h2A, wdata 8'hEB, rw=0 → m_addr=2A, m_data_in=EB, m_enable high until m_ready falls; done[0] pulses once when ready returns; err=0.
- Single read: req[2], rw=1; master model returns 8'h5C → rdata=8'h5C in done[2] cycle; gnt=4'b0100 throughout.
- Contention: req=4'b1111 held continuously → grant order 0,1,2,3,0; exactly one gnt bit at a time, never overlapping.
- Master busy at request (m_ready=0 for 20 cycles) → m_enable stays 0 and gnt stays 0 until m_ready=1.
- Reset mid-BUSY: rst_n low → all outputs 0 immediately; after release, pending req[1] is granted before req[3] (pointer=0).
- Timeout (I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): master holds m_ready=0 → done and err pulse together 16 cycles after issue; next request proceeds normally.
